// File: rtl/seg_pkg.sv
// Shared types and the segment map for the 7-segment display path.
// Segment patterns are {g,f,e,d,c,b,a}, active-low.
// Codes: 0-9, 10=A, 11=b, 12=C, 13=d, 14=E, 15=blank.
package seg_pkg;

  typedef logic [3:0] seg_code_t;
  typedef logic [6:0] seg_pat_t;

  typedef enum logic [0:0] {
    S_BLANK = 1'b0,
    S_DRIVE = 1'b1
  } scan_state_t;

  localparam seg_code_t SEG_BLANK = 4'hF;

  // Indexed by display code; entry 15 is first in the concatenation.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b1111111,  // 15 blank
    7'b0000110,  // 14 E
    7'b0100001,  // 13 d
    7'b1000110,  // 12 C
    7'b0000011,  // 11 b
    7'b0001000,  // 10 A
    7'b0010000,  //  9
    7'b0000000,  //  8
    7'b1111000,  //  7
    7'b0000010,  //  6
    7'b0010010,  //  5
    7'b0011001,  //  4
    7'b0110000,  //  3
    7'b0100100,  //  2
    7'b1111001,  //  1
    7'b1000000   //  0
  };

endpackage

// File: rtl/seg_decode.sv
// Combinational display-code to segment-pattern lookup.
// Ports:
//   code   display code 0..15
//   seg_c  segment pattern {g,f,e,d,c,b,a}, active-low (combinational)
module seg_decode
  import seg_pkg::*;
(
  input  seg_code_t code,
  output seg_pat_t  seg_c
);

  always_comb begin
    seg_c = SEG_TABLE[code];
  end

endmodule

// File: rtl/seg_scan_drv.sv
// Multiplexed common-anode 7-segment driver. Codes scroll in from the right
// through a shift buffer; each digit slot begins with a blanking gap so the
// previous digit's pattern never ghosts onto the next one.
// Optional feature macro: SEG_SCAN_DP_EN adds a decimal-point buffer and output.
// Ports:
//   clk         system clock
//   rst         synchronous reset, active-high
//   code_in     display code from the sequencer
//   code_valid  one-cycle strobe: shift code_in into the buffer
//   clear       blank every buffer entry (wins over code_valid)
//   dp_in       decimal point captured with code_valid (SEG_SCAN_DP_EN only)
//   dp_n        decimal point, active-low (SEG_SCAN_DP_EN only)
//   seg         segments {g,f,e,d,c,b,a}, active-low
//   dig_n       digit enables, active-low, bit 0 = rightmost digit
module seg_scan_drv
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIG   = 4,
  parameter int unsigned SCAN_DIV  = 50_000,
  parameter int unsigned BLANK_CYC = 500
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         code_in,
  input  logic               code_valid,
  input  logic               clear,
`ifdef SEG_SCAN_DP_EN
  input  logic               dp_in,
  output logic               dp_n,
`endif
  output logic [6:0]         seg,
  output logic [NUM_DIG-1:0] dig_n
);

  localparam int unsigned CNT_W = $clog2(SCAN_DIV);
  localparam int unsigned IDX_W = $clog2(NUM_DIG);

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIG - 1);

  scan_state_t          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  seg_code_t            code_buf [NUM_DIG];
  seg_pat_t             cur_pat_c;
  seg_pat_t             seg_d;
  logic [NUM_DIG-1:0]   dig_n_d;

  // Shift buffer: newest code enters at digit 0, oldest drops off the left.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int i = 0; i < int'(NUM_DIG); i++) code_buf[i] <= SEG_BLANK;
    end else if (code_valid) begin
      code_buf[0] <= code_in;
      for (int i = 1; i < int'(NUM_DIG); i++) code_buf[i] <= code_buf[i-1];
    end
  end

  // Pattern for the digit currently selected by the scan index.
  seg_decode u_decode (
    .code  (code_buf[idx_q]),
    .seg_c (cur_pat_c)
  );

  // Scan state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_BLANK;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic and output targets for the scan FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    seg_d   = '1;
    dig_n_d = '1;
    case (state_q)
      S_BLANK: begin
        if (cnt_q == BLANK_LAST) state_d = S_DRIVE;
      end
      S_DRIVE: begin
        seg_d   = cur_pat_c;
        dig_n_d = ~(NUM_DIG'(1) << idx_q);
        if (cnt_q == CNT_LAST) begin
          state_d = S_BLANK;
          idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = S_BLANK;
      end
    endcase
  end

  // Registered display outputs, one cycle behind the scan state.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg   <= '1;
      dig_n <= '1;
    end else begin
      seg   <= seg_d;
      dig_n <= dig_n_d;
    end
  end

`ifdef SEG_SCAN_DP_EN
  logic [NUM_DIG-1:0] dp_buf;
  logic               dp_n_d;

  // Decimal points ride alongside the code buffer.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      dp_buf <= '0;
    end else if (code_valid) begin
      dp_buf <= {dp_buf[NUM_DIG-2:0], dp_in};
    end
  end

  always_comb begin
    dp_n_d = 1'b1;
    if (state_q == S_DRIVE) dp_n_d = ~dp_buf[idx_q];
  end

  always_ff @(posedge clk) begin
    if (rst) dp_n <= 1'b1;
    else     dp_n <= dp_n_d;
  end
`else
  // Decimal-point path not built; dp ports are absent.
`endif

endmodule

// File: tb/tb_seg_scan_drv.sv
// Directed bench for seg_scan_drv with SCAN_DIV=10, BLANK_CYC=2, NUM_DIG=4.
module tb_seg_scan_drv;

  localparam logic [6:0] PB = 7'b1111111;
  localparam logic [6:0] P0 = 7'b1000000;
  localparam logic [6:0] P1 = 7'b1111001;
  localparam logic [6:0] P2 = 7'b0100100;
  localparam logic [6:0] P3 = 7'b0110000;
  localparam logic [6:0] P4 = 7'b0011001;
  localparam logic [6:0] P5 = 7'b0010010;
  localparam logic [6:0] P6 = 7'b0000010;
  localparam logic [6:0] P7 = 7'b1111000;
  localparam logic [6:0] P8 = 7'b0000000;
  localparam logic [6:0] P9 = 7'b0010000;
  localparam logic [6:0] PA = 7'b0001000;
  localparam logic [6:0] Pb = 7'b0000011;
  localparam logic [6:0] PC = 7'b1000110;
  localparam logic [6:0] Pd = 7'b0100001;
  localparam logic [6:0] PE = 7'b0000110;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] code_in = 4'h0;
  logic       code_valid = 1'b0;
  logic       clear = 1'b0;
  logic [6:0] seg;
  logic [3:0] dig_n;
`ifdef SEG_SCAN_DP_EN
  logic       dp_in = 1'b0;
  logic       dp_n;
`endif

  int k = 0;
  int n_checks = 0;
  int n_fail = 0;

  // Record: stimulus strobes (codes[0] first) and per-digit expectations.
  typedef struct packed {
    logic             do_clear;
    logic [2:0]       n;
    logic [3:0][3:0]  codes;
    logic [3:0]       dps;
    logic [3:0][6:0]  exp;
    logic [3:0]       exp_dp;
  } vec_t;

  vec_t vecs [9];

  seg_scan_drv #(
    .NUM_DIG   (4),
    .SCAN_DIV  (10),
    .BLANK_CYC (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .code_in    (code_in),
    .code_valid (code_valid),
    .clear      (clear),
`ifdef SEG_SCAN_DP_EN
    .dp_in      (dp_in),
    .dp_n       (dp_n),
`endif
    .seg        (seg),
    .dig_n      (dig_n)
  );

  always #5 clk = ~clk;

  // Posedges since the last reset edge; sampled on negedges.
  always @(posedge clk) begin
    if (rst) k <= 0;
    else     k <= k + 1;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int id, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec=%0d k=%0d got=%b expected=%b", nm, id, k, act, exp);
    end
  endtask

  function automatic logic [3:0] exp_dig(input int kk);
    int ph;
    int sl;
    ph = (kk - 1) % 10;
    sl = ((kk - 1) / 10) % 4;
    if (ph < 2) return 4'hF;
    return ~(4'b0001 << sl);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_seg", -1, 8'(seg), 8'(PB));
    chk("reset_dig_n", -1, 8'(dig_n), 8'hF);
`ifdef SEG_SCAN_DP_EN
    chk("reset_dp_n", -1, 8'(dp_n), 8'h1);
`endif
    rst = 1'b0;
  endtask

  task automatic apply_vec(input int id);
    for (int j = 0; j < int'(vecs[id].n); j++) begin
      @(negedge clk);
      code_valid = 1'b1;
      clear      = vecs[id].do_clear;
      code_in    = vecs[id].codes[j];
`ifdef SEG_SCAN_DP_EN
      dp_in      = vecs[id].dps[j];
`endif
    end
    @(negedge clk);
    code_valid = 1'b0;
    clear      = 1'b0;
`ifdef SEG_SCAN_DP_EN
    dp_in      = 1'b0;
`endif
  endtask

  // One full scan period compared against the record's per-digit expectations.
  task automatic check_period(input int id);
    int sl;
    logic blank;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      sl    = ((k - 1) / 10) % 4;
      blank = ((k - 1) % 10) < 2;
      chk("seg", id, 8'(seg), 8'(blank ? PB : vecs[id].exp[sl]));
      chk("dig_n", id, 8'(dig_n), 8'(exp_dig(k)));
`ifdef SEG_SCAN_DP_EN
      chk("dp_n", id, 8'(dp_n), 8'(blank ? 1'b1 : vecs[id].exp_dp[sl]));
`endif
    end
  endtask

  task automatic wait_phase(input int target);
    int tries;
    tries = 0;
    while ((k % 40) != target && tries < 60) begin
      @(negedge clk);
      tries++;
    end
    chk("wait_phase", target, 8'(tries < 60), 8'h1);
  endtask

  initial begin
    vecs[0] = '{do_clear: 1'b0, n: 3'd4, codes: {4'd4, 4'd3, 4'd2, 4'd1}, dps: 4'b0000,
                exp: {P1, P2, P3, P4}, exp_dp: 4'b1111};
    vecs[1] = '{do_clear: 1'b0, n: 3'd1, codes: {4'd0, 4'd0, 4'd0, 4'd0}, dps: 4'b0000,
                exp: {P2, P3, P4, P0}, exp_dp: 4'b1111};
    vecs[2] = '{do_clear: 1'b0, n: 3'd1, codes: {4'd0, 4'd0, 4'd0, 4'd14}, dps: 4'b0000,
                exp: {P3, P4, P0, PE}, exp_dp: 4'b1111};
    vecs[3] = '{do_clear: 1'b0, n: 3'd4, codes: {4'hD, 4'hC, 4'hB, 4'hA}, dps: 4'b0000,
                exp: {PA, Pb, PC, Pd}, exp_dp: 4'b1111};
    vecs[4] = '{do_clear: 1'b0, n: 3'd4, codes: {4'd9, 4'd7, 4'd6, 4'd5}, dps: 4'b0000,
                exp: {P5, P6, P7, P9}, exp_dp: 4'b1111};
    vecs[5] = '{do_clear: 1'b1, n: 3'd1, codes: {4'd0, 4'd0, 4'd0, 4'd8}, dps: 4'b0001,
                exp: {PB, PB, PB, PB}, exp_dp: 4'b1111};
    vecs[6] = '{do_clear: 1'b0, n: 3'd2, codes: {4'd0, 4'd0, 4'd6, 4'd5}, dps: 4'b0001,
                exp: {PB, PB, P5, P6}, exp_dp: 4'b1101};
    vecs[7] = '{do_clear: 1'b0, n: 3'd2, codes: {4'd0, 4'd0, 4'hF, 4'd8}, dps: 4'b0000,
                exp: {P5, P6, P8, PB}, exp_dp: 4'b0111};
    vecs[8] = '{do_clear: 1'b0, n: 3'd0, codes: '0, dps: 4'b0000,
                exp: {PB, PB, PB, PB}, exp_dp: 4'b1111};

    do_reset();

    // Idle after reset: blank segments, scanning enables with blank gaps.
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      chk("idle_seg", -1, 8'(seg), 8'(PB));
      chk("idle_dig_n", -1, 8'(dig_n), 8'(exp_dig(k)));
`ifdef SEG_SCAN_DP_EN
      chk("idle_dp_n", -1, 8'(dp_n), 8'h1);
`endif
    end

    for (int v = 0; v < 8; v++) begin
      apply_vec(v);
      check_period(v);
    end

    // Buffer update inside digit 0's drive window: seg changes two edges later.
    wait_phase(3);
    code_valid = 1'b1;
    code_in    = 4'd3;
    @(negedge clk);
    code_valid = 1'b0;
    chk("lat_old_seg", -1, 8'(seg), 8'(PB));
    chk("lat_old_dig_n", -1, 8'(dig_n), 8'(4'b1110));
    @(negedge clk);
    chk("lat_new_seg", -1, 8'(seg), 8'(P3));
    chk("lat_new_dig_n", -1, 8'(dig_n), 8'(4'b1110));

    // Reset while driving digit 2: everything returns to reset values.
    wait_phase(25);
    chk("pre_rst_dig_n", -1, 8'(dig_n), 8'(4'b1011));
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_seg", -1, 8'(seg), 8'(PB));
    chk("mid_rst_dig_n", -1, 8'(dig_n), 8'hF);
`ifdef SEG_SCAN_DP_EN
    chk("mid_rst_dp_n", -1, 8'(dp_n), 8'h1);
`endif
    rst = 1'b0;
    check_period(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
